// File: rtl/data_mem_ctrl.sv
// Data-memory controller: single-port word RAM, one-stall loads, zero-stall stores.
// Define DMEM_STORE_BUFFER_EN to add the one-entry store buffer with load forwarding.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        stall,
  output logic        err,
  output logic        sb_pending
);

  typedef enum logic {IDLE, RD} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic [31:0]     r_rdWord;
  logic [31:0]     r_fwdData;
  logic [3:0]      r_fwdMask;
  logic            r_rdOor;
  logic            r_err;
  logic [31:0]     r_lastRd;

  logic            w_req;
  logic            w_load;
  logic            w_store;
  logic            w_oor;
  logic            w_storeOk;
  logic [AW-1:0]   w_idx;
  logic [3:0]      w_we;
  logic [AW-1:0]   w_wIdx;
  logic [31:0]     w_wData;
  logic [3:0]      w_fwdMask;
  logic [31:0]     w_fwdData;
  logic [31:0]     w_merged;
  logic            w_unused;

  assign w_req     = mem_en & ~cs;
  assign w_load    = w_req & wr;
  assign w_store   = w_req & ~wr;
  assign w_oor     = |addr[31:AW+2];
  assign w_idx     = addr[AW+1:2];
  assign w_storeOk = !rst && (r_state == IDLE) && w_store && !w_oor && (|mask);
  assign w_unused  = &{1'b0, addr[1:0]};

  // stall doubles as the array read-issue strobe
  always_comb begin
    w_nextState = r_state;
    stall       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && w_load) begin
          w_nextState = RD;
          stall       = 1'b1;
        end
      end
      RD:      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

`ifdef DMEM_STORE_BUFFER_EN
  logic            r_sbValid;
  logic [AW-1:0]   r_sbIdx;
  logic [31:0]     r_sbData;
  logic [3:0]      r_sbMask;
  logic            w_drain;

  // A full buffer drains in the same cycle a new store replaces it
  assign w_drain = r_sbValid && !stall && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sbValid <= 1'b0;
    end else if (w_storeOk) begin
      r_sbValid <= 1'b1;
      r_sbIdx   <= w_idx;
      r_sbData  <= data_wr;
      r_sbMask  <= mask;
    end else if (w_drain) begin
      r_sbValid <= 1'b0;
    end
  end

  assign w_we       = w_drain ? r_sbMask : 4'b0000;
  assign w_wIdx     = r_sbIdx;
  assign w_wData    = r_sbData;
  assign w_fwdMask  = (r_sbValid && (r_sbIdx == w_idx)) ? r_sbMask : 4'b0000;
  assign w_fwdData  = r_sbData;
  assign sb_pending = r_sbValid;
`else
  assign w_we       = w_storeOk ? mask : 4'b0000;
  assign w_wIdx     = w_idx;
  assign w_wData    = data_wr;
  assign w_fwdMask  = 4'b0000;
  assign w_fwdData  = 32'h0;
  assign sb_pending = 1'b0;
`endif

  // RAM is never reset; reads and writes never share a cycle
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_we[b]) r_mem[w_wIdx][8*b +: 8] <= w_wData[8*b +: 8];
    end
    if (stall) r_rdWord <= r_mem[w_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwdMask <= 4'b0000;
      r_fwdData <= 32'h0;
      r_rdOor   <= 1'b0;
      r_err     <= 1'b0;
      r_lastRd  <= 32'h0;
    end else begin
      r_err <= (r_state == IDLE) && w_req && w_oor;
      if (stall) begin
        r_fwdMask <= w_fwdMask;
        r_fwdData <= w_fwdData;
        r_rdOor   <= w_oor;
      end
      if (r_state == RD) r_lastRd <= w_merged;
    end
  end

  always_comb begin
    w_merged = 32'h0;
    if (!r_rdOor) begin
      for (int b = 0; b < 4; b++) begin
        w_merged[8*b +: 8] = r_fwdMask[b] ? r_fwdData[8*b +: 8] : r_rdWord[8*b +: 8];
      end
    end
  end

  assign data_rd = (!rst && r_state == RD) ? w_merged : r_lastRd;
  assign err     = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl; load expectations are queued at issue and
// checked by a monitor in the cycle after stall is seen.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        stall;
  logic        err;
  logic        sb_pending;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t sbq[$];
  logic sawStall = 1'b0;
  logic sbpAtIssue;
  logic bufOn;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem_en     (mem_en),
    .cs         (cs),
    .wr         (wr),
    .mask       (mask),
    .addr       (addr),
    .data_wr    (data_wr),
    .data_rd    (data_rd),
    .stall      (stall),
    .err        (err),
    .sb_pending (sb_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_en  = 1'b0;
    cs      = 1'b1;
    wr      = 1'b1;
    mask    = 4'b0000;
    addr    = 32'h0;
    data_wr = 32'h0;
  endtask

  // Drives one request starting just after a rising edge; loads are held through RD
  task automatic applyStimulus(input string name, input logic isLoad, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] m,
                               input logic [31:0] expData, input logic expErr);
    exp_t e;
    mem_en  = 1'b1;
    cs      = 1'b0;
    wr      = isLoad;
    addr    = a;
    data_wr = d;
    mask    = m;
    if (isLoad) begin
      e.data = expData;
      e.err  = expErr;
      e.name = name;
      sbq.push_back(e);
    end
    @(negedge clk);
    sbpAtIssue = sb_pending;
    checkOutput({name, "_stall"}, {31'b0, stall}, {31'b0, isLoad});
    tick();
    if (isLoad) begin
      @(negedge clk);
      checkOutput({name, "_rdstall"}, {31'b0, stall}, 32'h0);
      tick();
    end
    idle();
  endtask

  // Monitor: the cycle after stall is seen is the RD cycle carrying data_rd
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sawStall = 1'b0;
    end else begin
      if (sawStall) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rd: got %h expected no load", data_rd);
        end else begin
          e = sbq.pop_front();
          checkOutput({e.name, "_data"}, data_rd, e.data);
          checkOutput({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
        end
      end
      sawStall = stall;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] b2bAddr [4];
    logic [31:0] b2bData [4];
    longint      tStart;
    longint      tEnd;

`ifdef DMEM_STORE_BUFFER_EN
    bufOn = 1'b1;
`else
    bufOn = 1'b0;
`endif

    b2bAddr[0] = 32'h44; b2bData[0] = 32'h0BADF00D;
    b2bAddr[1] = 32'h10; b2bData[1] = 32'hDEADBEEF;
    b2bAddr[2] = 32'h20; b2bData[2] = 32'h11AA3344;
    b2bAddr[3] = 32'h40; b2bData[3] = 32'hCAFEF00D;

    // Reset with a load request present: everything must stay quiet
    idle();
    rst    = 1'b1;
    mem_en = 1'b1;
    cs     = 1'b0;
    addr   = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_data_rd", data_rd, 32'h0);
    checkOutput("rst_stall", {31'b0, stall}, 32'h0);
    checkOutput("rst_err", {31'b0, err}, 32'h0);
    checkOutput("rst_sb_pending", {31'b0, sb_pending}, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    $display("[TB] basic store then load");
    applyStimulus("sw10", 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("sbp_after_store", {31'b0, sb_pending}, {31'b0, bufOn});
    tick();
    @(negedge clk);
    checkOutput("sbp_drained", {31'b0, sb_pending}, 32'h0);
    tick();
    applyStimulus("lw10", 1'b1, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    checkOutput("data_rd_hold", data_rd, 32'hDEADBEEF);
    tick();

    $display("[TB] word store, byte store, merged load");
    applyStimulus("sw20", 1'b0, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
    applyStimulus("sb22", 1'b0, 32'h22, 32'h00AA0000, 4'b0100, 32'h0, 1'b0);
    applyStimulus("lw20", 1'b1, 32'h20, 32'h0, 4'h0, 32'h11AA3344, 1'b0);

    $display("[TB] store immediately followed by load");
    applyStimulus("sw40", 1'b0, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    applyStimulus("lw40", 1'b1, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    checkOutput("sbp_after_rd", {31'b0, sb_pending}, 32'h0);
    tick();

    $display("[TB] ten back-to-back loads after one store");
    applyStimulus("sw44", 1'b0, 32'h44, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
    tStart = $time;
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("b2b%0d", i), 1'b1, b2bAddr[i%4], 32'h0, 4'h0, b2bData[i%4], 1'b0);
      if (i == 1) checkOutput("sbp_b2b", {31'b0, sbpAtIssue}, 32'h0);
    end
    tEnd = $time;
    checkOutput("b2b_cycles", 32'((tEnd - tStart) / 10), 32'd20);

    $display("[TB] out-of-range accesses");
    applyStimulus("sw00", 1'b0, 32'h0, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0);
    tick();
    tick();
    applyStimulus("lw_oor", 1'b1, 32'h0001_0000, 32'h0, 4'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("err_once", {31'b0, err}, 32'h0);
    tick();
    applyStimulus("sw_oor", 1'b0, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("err_store", {31'b0, err}, 32'h1);
    checkOutput("sbp_oor_drop", {31'b0, sb_pending}, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("err_store_end", {31'b0, err}, 32'h0);
    tick();
    applyStimulus("lw00", 1'b1, 32'h0, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0);

    $display("[TB] zero-mask store");
    applyStimulus("sw_m0", 1'b0, 32'h10, 32'h12345678, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("sbp_mask0", {31'b0, sb_pending}, 32'h0);
    tick();
    applyStimulus("lw10_m0", 1'b1, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    $display("[TB] reset before drain");
    applyStimulus("sw_rst", 1'b0, 32'h10, 32'h77777777, 4'hF, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("sbp_rst", {31'b0, sb_pending}, 32'h0);
    checkOutput("data_rd_rst", data_rd, 32'h0);
    tick();
    rst = 1'b0;
    applyStimulus("lw10_rst", 1'b1, 32'h10, 32'h0, 4'h0,
                  bufOn ? 32'hDEADBEEF : 32'h77777777, 1'b0);

    tick();
    tick();
    checkOutput("queue_drained", sbq.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
